// File: rtl/prog_loader.sv
// Boot-time loader: unpacks a framed byte stream into words and writes them into
// instruction or data memory, holding the core off until an END command arrives.
module prog_loader #(
  parameter int WORD_W     = 32,
  parameter int INST_DEPTH = 200,
  parameter int DATA_DEPTH = 10000,
  parameter int INST_AW    = $clog2(INST_DEPTH),
  parameter int DATA_AW    = $clog2(DATA_DEPTH)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               inst_we,
  output logic [INST_AW-1:0] inst_addr,
  output logic [WORD_W-1:0]  inst_wdata,
  output logic               data_we,
  output logic [DATA_AW-1:0] data_addr,
  output logic [WORD_W-1:0]  data_wdata,
  output logic [31:0]        words_written,
  output logic               done,
  output logic               err
);

  localparam int BYTES = WORD_W / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
  localparam logic [16:0]    INST_LIM  = 17'(INST_DEPTH);
  localparam logic [16:0]    DATA_LIM  = 17'(DATA_DEPTH);

  localparam logic [7:0] CMD_INST = 8'h01;
  localparam logic [7:0] CMD_DATA = 8'h02;
  localparam logic [7:0] CMD_END  = 8'hFF;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADR_H,
    S_ADR_L,
    S_CNT_H,
    S_CNT_L,
    S_PAY,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_reg, state_next;

  logic               live_reg;
  logic               target_reg;     // 0 = instruction memory, 1 = data memory
  logic [15:0]        addr_reg;
  logic [15:0]        cnt_reg;
  logic [16:0]        idx_reg;
  logic [BCW-1:0]     byte_reg;
  logic               inst_we_reg;
  logic [INST_AW-1:0] inst_addr_reg;
  logic [WORD_W-1:0]  inst_wdata_reg;
  logic               data_we_reg;
  logic [DATA_AW-1:0] data_addr_reg;
  logic [WORD_W-1:0]  data_wdata_reg;
  logic [31:0]        count_reg;
  logic               done_reg;
  logic               err_reg;

  logic               accept;
  logic               last_byte;
  logic               last_word;
  logic               word_end;
  logic [16:0]        addr_sum;
  logic               inst_ok;
  logic               data_ok;
  logic               cmd_ok;
  logic [WORD_W-1:0]  word_full;

  // in_ready is gated by live_reg so it stays low until the first clock after reset.
  assign in_ready  = live_reg && (state_reg != S_DONE) && (state_reg != S_ERR);
  assign accept    = in_valid && in_ready;
  assign last_byte = (byte_reg == LAST_BYTE);
  assign last_word = ((idx_reg + 17'd1) == {1'b0, cnt_reg});
  assign word_end  = accept && (state_reg == S_PAY) && last_byte;
  assign cmd_ok    = (in_data == CMD_INST) || (in_data == CMD_DATA);

  // 17-bit sum so a 16-bit address overflow shows up as out of range.
  assign addr_sum = {1'b0, addr_reg} + idx_reg;
  assign inst_ok  = !addr_sum[16] && (addr_sum < INST_LIM);
  assign data_ok  = !addr_sum[16] && (addr_sum < DATA_LIM);

  generate
    if (BYTES > 1) begin : g_shift
      logic [WORD_W-9:0] shift_reg;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          shift_reg <= '0;
        end else if (accept && (state_reg == S_PAY)) begin
          shift_reg <= word_full[WORD_W-9:0];
        end
      end

      assign word_full = {shift_reg, in_data};
    end else begin : g_noshift
      assign word_full = in_data;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= S_CMD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      case (state_reg)
        S_CMD: begin
          if (cmd_ok) begin
            state_next = S_ADR_H;
          end else if (in_data == CMD_END) begin
            state_next = S_DONE;
          end else begin
            state_next = S_ERR;
          end
        end
        S_ADR_H: state_next = S_ADR_L;
        S_ADR_L: state_next = S_CNT_H;
        S_CNT_H: state_next = S_CNT_L;
        S_CNT_L: begin
          if ({cnt_reg[15:8], in_data} != 16'd0) begin
            state_next = S_PAY;
          end else begin
            state_next = S_CMD;
          end
        end
        S_PAY: begin
          if (last_byte && last_word) begin
            state_next = S_CMD;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  // Frame header capture and payload byte/word counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live_reg   <= 1'b0;
      target_reg <= 1'b0;
      addr_reg   <= '0;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      byte_reg   <= '0;
    end else begin
      live_reg <= 1'b1;
      if (accept) begin
        case (state_reg)
          S_CMD:   target_reg <= (in_data == CMD_DATA);
          S_ADR_H: addr_reg[15:8] <= in_data;
          S_ADR_L: addr_reg[7:0] <= in_data;
          S_CNT_H: cnt_reg[15:8] <= in_data;
          S_CNT_L: begin
            cnt_reg[7:0] <= in_data;
            idx_reg      <= '0;
            byte_reg     <= '0;
          end
          S_PAY: begin
            if (last_byte) begin
              byte_reg <= '0;
              idx_reg  <= idx_reg + 17'd1;
            end else begin
              byte_reg <= byte_reg + BCW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Memory write ports: one-cycle strobe after the final byte of a word; addr/wdata hold otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_we_reg    <= 1'b0;
      inst_addr_reg  <= '0;
      inst_wdata_reg <= '0;
      data_we_reg    <= 1'b0;
      data_addr_reg  <= '0;
      data_wdata_reg <= '0;
      count_reg      <= '0;
    end else begin
      inst_we_reg <= 1'b0;
      data_we_reg <= 1'b0;
      if (word_end) begin
        if (!target_reg && inst_ok) begin
          inst_we_reg    <= 1'b1;
          inst_addr_reg  <= addr_sum[INST_AW-1:0];
          inst_wdata_reg <= word_full;
          count_reg      <= count_reg + 32'd1;
        end else if (target_reg && data_ok) begin
          data_we_reg    <= 1'b1;
          data_addr_reg  <= addr_sum[DATA_AW-1:0];
          data_wdata_reg <= word_full;
          count_reg      <= count_reg + 32'd1;
        end
      end
    end
  end

  // done and err are sticky until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      if (accept && (state_reg == S_CMD)) begin
        if (in_data == CMD_END) begin
          done_reg <= 1'b1;
        end else if (!cmd_ok) begin
          err_reg <= 1'b1;
        end
      end
      if (word_end && (target_reg ? !data_ok : !inst_ok)) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign inst_we       = inst_we_reg;
  assign inst_addr     = inst_addr_reg;
  assign inst_wdata    = inst_wdata_reg;
  assign data_we       = data_we_reg;
  assign data_addr     = data_addr_reg;
  assign data_wdata    = data_wdata_reg;
  assign words_written = count_reg;
  assign done          = done_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frames are streamed byte by byte and every
// memory write strobe is logged and compared against hand-computed values.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        inst_we;
  logic [7:0]  inst_addr;
  logic [31:0] inst_wdata;
  logic        data_we;
  logic [13:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] words_written;
  logic        done;
  logic        err;

  prog_loader dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .inst_we       (inst_we),
    .inst_addr     (inst_addr),
    .inst_wdata    (inst_wdata),
    .data_we       (data_we),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .words_written (words_written),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
    logic [31:0] ww;
  } wr_t;

  wr_t        inst_q[$];
  wr_t        data_q[$];
  logic [7:0] seq[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(negedge clk) begin
    cyc++;
    if (inst_we) inst_q.push_back('{32'(inst_addr), inst_wdata, cyc, words_written});
    if (data_we) data_q.push_back('{32'(data_addr), data_wdata, cyc, words_written});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check_eq("accept_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input bit gaps);
    foreach (seq[i]) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(seq[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    in_valid = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(1);
    inst_q.delete();
    data_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(2);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_words", 64'(words_written), 64'd0);
    check_eq("rst_inst_we", 64'(inst_we), 64'd0);
    rstn = 1'b1;
    idle(1);
    check_eq("rel_in_ready", 64'(in_ready), 64'd1);

    // Two instruction words back to back
    seq = {8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h00,
           8'hAF, 8'hDF, 8'h00, 8'h00};
    send_seq(1'b0);
    idle(3);
    check_eq("t1_inst_n", 64'(inst_q.size()), 64'd2);
    if (inst_q.size() == 2) begin
      check_eq("t1_addr0", 64'(inst_q[0].addr), 64'd0);
      check_eq("t1_data0", 64'(inst_q[0].data), 64'h20010000);
      check_eq("t1_ww0", 64'(inst_q[0].ww), 64'd1);
      check_eq("t1_addr1", 64'(inst_q[1].addr), 64'd1);
      check_eq("t1_data1", 64'(inst_q[1].data), 64'hAFDF0000);
      check_eq("t1_spacing", 64'(inst_q[1].cyc - inst_q[0].cyc), 64'd4);
    end
    check_eq("t1_words", 64'(words_written), 64'd2);
    check_eq("t1_err", 64'(err), 64'd0);
    check_eq("t1_data_n", 64'(data_q.size()), 64'd0);
    inst_q.delete();

    // Data segment followed by END
    seq = {8'h02, 8'h00, 8'h03, 8'h00, 8'h01, 8'h40, 8'h80, 8'h00, 8'h00};
    send_seq(1'b0);
    check_eq("t2_done_before", 64'(done), 64'd0);
    send_byte(8'hFF);
    check_eq("t2_done", 64'(done), 64'd1);
    check_eq("t2_in_ready", 64'(in_ready), 64'd0);
    idle(3);
    check_eq("t2_data_n", 64'(data_q.size()), 64'd1);
    if (data_q.size() == 1) begin
      check_eq("t2_addr", 64'(data_q[0].addr), 64'd3);
      check_eq("t2_data", 64'(data_q[0].data), 64'h40800000);
    end
    check_eq("t2_inst_n", 64'(inst_q.size()), 64'd0);
    check_eq("t2_words", 64'(words_written), 64'd3);
    check_eq("t2_ready_held", 64'(in_ready), 64'd0);

    // Instruction range boundary: second word at 200 is dropped
    do_reset();
    seq = {8'h01, 8'h00, 8'hC7, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88, 8'hFF};
    send_seq(1'b0);
    idle(3);
    check_eq("t3_inst_n", 64'(inst_q.size()), 64'd1);
    if (inst_q.size() == 1) begin
      check_eq("t3_addr", 64'(inst_q[0].addr), 64'd199);
      check_eq("t3_data", 64'(inst_q[0].data), 64'h11223344);
    end
    check_eq("t3_err", 64'(err), 64'd1);
    check_eq("t3_done", 64'(done), 64'd1);
    check_eq("t3_words", 64'(words_written), 64'd1);

    // Asynchronous reset clears every output
    #2;
    rstn = 1'b0;
    #1;
    check_eq("rst2_inst_addr", 64'(inst_addr), 64'd0);
    check_eq("rst2_inst_wdata", 64'(inst_wdata), 64'd0);
    check_eq("rst2_done", 64'(done), 64'd0);
    check_eq("rst2_err", 64'(err), 64'd0);
    check_eq("rst2_words", 64'(words_written), 64'd0);
    check_eq("rst2_in_ready", 64'(in_ready), 64'd0);
    idle(2);
    rstn = 1'b1;
    idle(1);
    inst_q.delete();
    data_q.delete();

    // Bad command locks the loader in error
    send_byte(8'h05);
    check_eq("t4_err", 64'(err), 64'd1);
    check_eq("t4_in_ready", 64'(in_ready), 64'd0);
    check_eq("t4_done", 64'(done), 64'd0);
    in_valid = 1'b1;
    in_data  = 8'h01;
    idle(6);
    in_valid = 1'b0;
    check_eq("t4_ready_held", 64'(in_ready), 64'd0);
    check_eq("t4_writes", 64'(inst_q.size() + data_q.size()), 64'd0);
    check_eq("t4_done_held", 64'(done), 64'd0);

    // Zero-count data segment, then one instruction word
    do_reset();
    seq = {8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
           8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_seq(1'b0);
    idle(3);
    check_eq("t5_data_n", 64'(data_q.size()), 64'd0);
    check_eq("t5_inst_n", 64'(inst_q.size()), 64'd1);
    if (inst_q.size() == 1) begin
      check_eq("t5_addr", 64'(inst_q[0].addr), 64'd0);
      check_eq("t5_data", 64'(inst_q[0].data), 64'hDEADBEEF);
    end
    check_eq("t5_err", 64'(err), 64'd0);

    // Data range boundary: 0x270F is the last data word
    do_reset();
    seq = {8'h02, 8'h27, 8'h0F, 8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D,
           8'h12, 8'h12, 8'h12, 8'h12};
    send_seq(1'b0);
    idle(3);
    check_eq("t6_data_n", 64'(data_q.size()), 64'd1);
    if (data_q.size() == 1) begin
      check_eq("t6_addr", 64'(data_q[0].addr), 64'h270F);
      check_eq("t6_data", 64'(data_q[0].data), 64'hCAFEF00D);
    end
    check_eq("t6_err", 64'(err), 64'd1);
    check_eq("t6_words", 64'(words_written), 64'd1);

    // Gapped stream with a reset after two payload bytes
    do_reset();
    seq = {8'h01, 8'h00, 8'h05, 8'h00, 8'h01, 8'hAA, 8'hBB};
    send_seq(1'b1);
    #2;
    rstn = 1'b0;
    idle(3);
    check_eq("t7_no_strobe", 64'(inst_q.size() + data_q.size()), 64'd0);
    rstn = 1'b1;
    idle(2);
    seq = {8'h01, 8'h00, 8'h05, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
    send_seq(1'b1);
    idle(3);
    check_eq("t7_inst_n", 64'(inst_q.size()), 64'd1);
    if (inst_q.size() == 1) begin
      check_eq("t7_addr", 64'(inst_q[0].addr), 64'd5);
      check_eq("t7_data", 64'(inst_q[0].data), 64'h12345678);
    end
    check_eq("t7_words", 64'(words_written), 64'd1);
    check_eq("t7_err", 64'(err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program/data loader for the core: replaces fixed, compile-time instruction/data images with a byte stream (UART receiver or testbench) that is unpacked into 32-bit words.
- Words are written through separate write ports into instruction memory and data memory.
- Holds the core in reset until an END command arrives, then asserts done. Depths and widths are parametrised.

Parameters:
- WORD_W, 32, memory word width; must be a multiple of 8.
- INST_DEPTH, 200, instruction memory words.
- DATA_DEPTH, 10000, data memory words.
- INST_AW, $clog2(INST_DEPTH), instruction address width.
- DATA_AW, $clog2(DATA_DEPTH), data address width.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts byte; transfer when in_valid&&in_ready.
- inst_we  out  1  instruction memory write strobe.
- inst_addr  out  INST_AW  instruction write address.
- inst_wdata  out  WORD_W  instruction write data.
- data_we  out  1  data memory write strobe.
- data_addr  out  DATA_AW  data write address.
- data_wdata  out  WORD_W  data write data.
- words_written  out  32  count of words actually written.
- done  out  1  END received; core may run.
- err  out  1  sticky protocol/range error.

Behaviour:
- Reset (async, rstn=0): state=CMD; in_ready=0 while reset is asserted, 1 from the first clk after release; all strobes, addresses, wdata, words_written, done, err = 0.
- Frame format: CMD byte, ADDR[15:8], ADDR[7:0], CNT[15:8], CNT[7:0], then CNT words of WORD_W/8 bytes each, MSB byte first.
  - CMD 0x01 = instruction segment.
  - CMD 0x02 = data segment.
  - CMD 0xFF = END (no further bytes).
- FSM states: CMD, ADR_H, ADR_L, CNT_H, CNT_L, PAY, DONE, ERR. Each accepted byte advances one step.
  - CMD + 0x01/0x02 -> ADR_H; latch target.
  - CMD + 0xFF -> DONE.
  - CMD + any other value -> ERR.
  - CNT_L -> PAY if CNT != 0, else -> CMD.
  - PAY -> CMD after the last byte of word CNT-1.
- in_ready=1 in CMD..PAY; 0 in DONE and ERR. The stream is never back-pressured in the other states.
- Word assembly: shift register, byte-granular. On acceptance of the final byte of a word, the following clk edge drives for exactly one cycle:
  - we=1 for the selected target;
  - addr = ADDR + word index;
  - wdata = assembled word.
- Write latency: 1 cycle after last-byte acceptance.
- Back-to-back words are never adjacent strobes; each word needs ≥ WORD_W/8 cycles.
- The non-selected target's we stays 0.
- addr/wdata hold their last value when we=0.
- Range check per word: ADDR + index ≥ depth of selected target ->
  - word is consumed but not written (we stays 0);
  - err set;
  - the FSM continues the frame normally;
  - words_written is not incremented.
- words_written increments by 1 in the same cycle as each we pulse. Wraps modulo 2^32.
- DONE: done=1, held until reset; in_valid is ignored.
- ERR (bad CMD): err=1, in_ready=0, held until reset; done stays 0.
- err is never cleared except by reset.
- Reset mid-frame: partial word discarded, no strobe, FSM back to CMD.
- Address arithmetic is 16-bit. Index overflow past 0xFFFF is an out-of-range word (err).

Test Plan:
- Stream 01 00 00 00 02 | 20 01 00 00 | AF DF 00 00 with in_valid held high -> inst_we pulses twice:
  - addr 0 / 0x20010000;
  - addr 1 / 0xAFDF0000;
  - pulses 4 cycles apart; words_written=2; err=0; data_we never 1.
- Data segment 02 00 03 00 01 40 80 00 00 then FF:
  - data_we once, addr 3, data 0x40800000;
  - done=1 on the cycle after FF is accepted; in_ready=0 thereafter.
- Range: 01 00 C7 00 02 plus 8 payload bytes (INST_DEPTH=200):
  - inst_we once at addr 199;
  - second word dropped, err=1;
  - FSM accepts a following FF -> done=1.
- Bad CMD 0x05 -> err=1, in_ready=0, done=0; further bytes not accepted. Deassert rstn -> all outputs 0.
- Zero count: 02 00 10 00 00 then 01 00 00 00 01 + 4 bytes -> no data_we; one inst_we at addr 0.
- Random in_valid gaps plus async reset asserted after 2 payload bytes -> no strobe; after release, a new full frame writes correctly.
